// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
// Owns the PC and issues in-order word fetches to instruction memory.
// Returned words are queued together with their PCs and handed to decode
// over a valid/ready interface. A redirect flushes the queue, reloads the
// PC and marks every in-flight fetch as stale so its response is dropped.
// Optional feature macro: FETCH_PERF_CNT_EN adds fetch/stall perf counters.
module fetch_unit #(
    parameter int                    BIT_WIDTH  = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [BIT_WIDTH-1:0]  imem_rsp_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [BIT_WIDTH-1:0]  inst_data,
    output logic [ADDR_WIDTH-1:0] inst_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]           perf_fetch_cnt,
    output logic [31:0]           perf_stall_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_V = (CNT_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        FETCH,
        STALL,
        REDIRECT
    } state_t;

    state_t state_q, state_nxt;

    logic [ADDR_WIDTH-1:0] pc_q;
    logic [CNT_W-1:0]      outst_q;   // requests accepted, response not yet seen
    logic [CNT_W-1:0]      drop_q;    // stale responses still to be discarded
    logic [CNT_W-1:0]      q_cnt_q;   // instruction queue occupancy
    logic [PTR_W-1:0]      pf_wr_q, pf_rd_q;
    logic [PTR_W-1:0]      q_wr_q, q_rd_q;

    // PC of every outstanding request, in issue order
    logic [ADDR_WIDTH-1:0] pf_mem [DEPTH];
    // instruction queue: word plus the PC it was fetched from
    logic [ADDR_WIDTH-1:0] q_pc   [DEPTH];
    logic [BIT_WIDTH-1:0]  q_data [DEPTH];

    logic             has_credit;
    logic             req_fire;
    logic             rsp_take;
    logic             q_push;
    logic             q_pop;
    logic [CNT_W-1:0] outst_nxt;

    // Outstanding requests plus buffered words never exceed DEPTH, so the
    // queue can always absorb every response that is still due.
    assign has_credit = ({1'b0, outst_q} + {1'b0, q_cnt_q}) < DEPTH_V;
    assign req_fire   = imem_req_valid && imem_req_ready;
    // a response with nothing outstanding is a protocol error and is ignored
    assign rsp_take   = imem_rsp_valid && (outst_q != '0);
    assign q_push     = rsp_take && (drop_q == '0) && !redirect_valid;
    assign q_pop      = inst_valid && inst_ready && !redirect_valid;
    assign outst_nxt  = outst_q + CNT_W'(req_fire) - CNT_W'(rsp_take);

    assign imem_req_addr = pc_q;
    assign inst_valid    = (q_cnt_q != '0);
    assign inst_data     = inst_valid ? q_data[q_rd_q] : '0;
    assign inst_pc       = inst_valid ? q_pc[q_rd_q]   : '0;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= FETCH;
        else     state_q <= state_nxt;
    end

    // Request gating and next-state: a redirect cycle never issues a request.
    // Valid can only drop by losing credit, and credit never shrinks while a
    // request waits for ready, so an asserted request holds until accepted.
    always_comb begin
        state_nxt      = state_q;
        imem_req_valid = 1'b0;
        if (!rst && !redirect_valid) imem_req_valid = has_credit;
        unique case (state_q)
            REDIRECT: state_nxt = FETCH;
            default:  state_nxt = (has_credit && imem_req_ready) ? FETCH : STALL;
        endcase
        if (redirect_valid) state_nxt = REDIRECT;
    end

    // PC, outstanding/drop bookkeeping and queue pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            outst_q <= '0;
            drop_q  <= '0;
            pf_wr_q <= '0;
            pf_rd_q <= '0;
            q_wr_q  <= '0;
            q_rd_q  <= '0;
            q_cnt_q <= '0;
        end else begin
            outst_q <= outst_nxt;
            if (req_fire) pf_wr_q <= pf_wr_q + 1'b1;
            if (rsp_take) pf_rd_q <= pf_rd_q + 1'b1;
            if (redirect_valid) begin
                pc_q    <= redirect_pc & ~ADDR_WIDTH'(3);
                // everything still in flight after this cycle is stale
                drop_q  <= outst_nxt;
                q_wr_q  <= '0;
                q_rd_q  <= '0;
                q_cnt_q <= '0;
            end else begin
                if (req_fire) pc_q <= pc_q + ADDR_WIDTH'(4);
                if (rsp_take && (drop_q != '0)) drop_q <= drop_q - 1'b1;
                if (q_push) q_wr_q <= q_wr_q + 1'b1;
                if (q_pop)  q_rd_q <= q_rd_q + 1'b1;
                q_cnt_q <= q_cnt_q + CNT_W'(q_push) - CNT_W'(q_pop);
            end
        end
    end

    // Storage arrays; contents are only observed through valid pointers
    always_ff @(posedge clk) begin
        if (req_fire) pf_mem[pf_wr_q] <= pc_q;
        if (q_push) begin
            q_pc[q_wr_q]   <= pf_mem[pf_rd_q];
            q_data[q_wr_q] <= imem_rsp_data;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Delivered-instruction and lost-request-slot counters
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (q_pop) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (!redirect_valid && !req_fire) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule
